trace_log: RTL and testbench
============================

# trace_log

Debug trace buffer for on-chip event capture: a FIFO of 2^LOG_DEPTH entries that records one WIDTH-bit word, with a free-running cycle stamp, on every cycle that wvalid is high. The host drains it over the PCIe debug read channel as 512-bit beats. Occupancy is reported to the tile register bus. The block also carries the tile's lowest-set-bit encoder, a combinational arbiter that clients use to pick which source to log or serve.

## Interface
- WIDTH, 224: bits per logged word; legal range 1..480.
- LOG_DEPTH, 10: log2 of entry count.
- IN_WIDTH, 8: encoder request width.
- OUT_WIDTH, 3: encoder index width, equal to $clog2(IN_WIDTH).
- Reset is rstn, synchronous, active-low. The clock is clk.
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- wvalid  in  1  capture wdata this cycle
- wdata  in  WIDTH  word to record
- pci_arvalid  in  1  host read request
- pci_arlen  in  8  beats in burst minus 1
- pci_arready  out  1  request accepted
- pci_rvalid  out  1  read beat valid
- pci_rdata  out  512  beat: {zeros, cycle[31:0], entry}
- pci_rlast  out  1  last beat of burst
- pci_rready  in  1  host accepts beat
- size  out  LOG_DEPTH+1  current entry count
- pick_in  in  IN_WIDTH  encoder requests
- pick_out  out  OUT_WIDTH  index of lowest set bit of pick_in

## Operation
- Storage is a circular buffer of 2^LOG_DEPTH entries. Each entry is {cycle[31:0], wdata}.
- cycle is a 32-bit counter: 0 in reset, +1 every cycle, wraps at 2^32.
- Write: when wvalid=1 and size < 2^LOG_DEPTH, store the entry at wptr and increment wptr.
- When full, writes are dropped. Stored data is never overwritten.
- Read FSM states:
  - R_IDLE: pci_arready=1. On arvalid, latch arlen into beats_left and go to R_DATA.
  - R_DATA: pci_rvalid=1.
    - pci_rdata = the entry at rptr, zero-extended to 512 bits. If the buffer is empty, the beat is all zeros.
    - pci_rlast = (beats_left==0).
    - On rready: pop the entry if non-empty, then decrement beats_left. After the last beat, return to R_IDLE.
- A burst always completes with arlen+1 beats, regardless of occupancy.
- Pointers are LOG_DEPTH bits wide and wrap modulo depth.
- size = count of stored entries, in the range 0..2^LOG_DEPTH.
- If a push and a pop occur in the same cycle, size is unchanged and both pointers advance.
- pick_out is purely combinational. It equals the index of the lowest 1 in pick_in, and is 0 when pick_in is all zero.

## Timing
- Reset values:
  - size=0, wptr=rptr=0, cycle=0.
  - pci_arready=0 during reset and 1 in the first cycle after reset.
  - pci_rvalid=0, pci_rlast=0, pci_rdata=0.
- Storage contents are not reset.
- A write in cycle N is visible to size in cycle N+1. It is readable from the first beat issued after N+1.
- Read latency: arvalid accepted in cycle N gives the first rvalid in cycle N+1 with data registered.
- pci_rdata stays stable while rvalid=1 and rready=0. Throughput is one beat per cycle under continuous rready.
- pci_rdata must reflect the current head entry, including an entry written in the cycle before the beat.
- Reset asserted mid-burst aborts the burst. The FSM goes to R_IDLE and the buffer empties. No further beats are issued for that burst.
- pick_out has zero-cycle latency.

## Test plan
- Reset, then 3 writes with wdata=1,2,3 in consecutive cycles → size=3. Then arlen=2 → 3 beats with low bits 1,2,3, cycle stamps incrementing by 1, rlast on beat 3, then size=0.
- Fill with LOG_DEPTH=4: 20 consecutive writes → size=16. Entries 0..15 are kept and 16..19 are dropped. Draining 16 beats returns values 0..15 in order.
- Empty read: arlen=3 on an empty buffer → 4 all-zero beats, rlast on the 4th, size stays 0.
- Simultaneous: with size=5, write on every cycle while draining at one beat per cycle → size stays 5 and data order is preserved.
- Backpressure: hold rready=0 for 10 cycles mid-burst → rvalid stays high, rdata is unchanged, and no pop occurs.
- Encoder: pick_in=8'b0110_1000 → 3. 8'b1000_0000 → 7. 8'b0000_0001 → 0. 8'b0 → 0.

Source files
------------

// File: rtl/trace_log.sv
// +----------------------------------------------------------------------------+
// | trace_log: cycle-stamped debug capture FIFO drained as 512-bit host bursts,  |
// | plus the tile's lowest-set-bit encoder.        Revision 1.0                |
// +----------------------------------------------------------------------------+
`default_nettype none

module trace_log #(
  parameter int WIDTH     = 224,
  parameter int LOG_DEPTH = 10,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wvalid,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 pci_arvalid,
  input  logic [7:0]           pci_arlen,
  output logic                 pci_arready,
  output logic                 pci_rvalid,
  output logic [511:0]         pci_rdata,
  output logic                 pci_rlast,
  input  logic                 pci_rready,
  output logic [LOG_DEPTH:0]   size,
  input  logic [IN_WIDTH-1:0]  pick_in,
  output logic [OUT_WIDTH-1:0] pick_out
);

  localparam int ENTRY_W = WIDTH + 32;
  localparam int DEPTH   = 1 << LOG_DEPTH;
  localparam int SZ_W    = LOG_DEPTH + 1;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  rstate_e              state_q, state_d;
  logic [7:0]           beats_q, beats_d;
  logic [LOG_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG_DEPTH-1:0] rptr_q, rptr_d;
  logic [SZ_W-1:0]      size_q, size_d;
  logic [31:0]          cycle_q;

  logic [ENTRY_W-1:0]   mem [DEPTH];

  logic                 empty;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (size_q == '0);
  assign full    = size_q[LOG_DEPTH];
  assign do_push = wvalid && !full;
  assign size    = size_q;

  // Read channel: outputs are gated by rstn so nothing is offered while reset is held.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    pci_arready = 1'b0;
    pci_rvalid  = 1'b0;
    pci_rlast   = 1'b0;
    pci_rdata   = '0;
    do_pop      = 1'b0;
    case (state_q)
      R_IDLE: begin
        pci_arready = rstn;
        if (pci_arvalid) begin
          beats_d = pci_arlen;
          state_d = R_DATA;
        end
      end
      R_DATA: begin
        pci_rvalid = rstn;
        pci_rlast  = rstn && (beats_q == 8'd0);
        // Combinational head read so a word written last cycle is already visible.
        if (rstn && !empty) begin
          pci_rdata = 512'(mem[rptr_q]);
        end
        if (pci_rready) begin
          do_pop = !empty;
          if (beats_q == 8'd0) begin
            state_d = R_IDLE;
          end else begin
            beats_d = beats_q - 8'd1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    size_d = size_q;
    if (do_push) begin
      wptr_d = wptr_q + LOG_DEPTH'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + LOG_DEPTH'(1);
    end
    if (do_push && !do_pop) begin
      size_d = size_q + SZ_W'(1);
    end else if (do_pop && !do_push) begin
      size_d = size_q - SZ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= R_IDLE;
      beats_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      size_q  <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      size_q  <= size_d;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Storage is deliberately not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (rstn && do_push) begin
      mem[wptr_q] <= {cycle_q, wdata};
    end
  end

  // Scan from the top so the lowest set bit is the last assignment to win.
  always_comb begin
    pick_out = '0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (pick_in[i]) begin
        pick_out = OUT_WIDTH'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trace_log.sv
// +----------------------------------------------------------------------------+
// | tb_trace_log: directed self-checking bench for trace_log.  Revision 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_trace_log;

  localparam int W     = 32;
  localparam int LD    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wvalid;
  logic [W-1:0]  wdata;
  logic          pci_arvalid;
  logic [7:0]    pci_arlen;
  logic          pci_arready;
  logic          pci_rvalid;
  logic [511:0]  pci_rdata;
  logic          pci_rlast;
  logic          pci_rready;
  logic [LD:0]   size;
  logic [7:0]    pick_in;
  logic [2:0]    pick_out;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] q [$];
  logic [31:0] m_cyc = '0;

  trace_log #(
    .WIDTH(W), .LOG_DEPTH(LD), .IN_WIDTH(8), .OUT_WIDTH(3)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wvalid(wvalid), .wdata(wdata),
    .pci_arvalid(pci_arvalid), .pci_arlen(pci_arlen), .pci_arready(pci_arready),
    .pci_rvalid(pci_rvalid), .pci_rdata(pci_rdata), .pci_rlast(pci_rlast),
    .pci_rready(pci_rready), .size(size),
    .pick_in(pick_in), .pick_out(pick_out)
  );

  always #5 clk = ~clk;

  // Free-running stamp as the host sees it: 0 in reset, +1 per cycle.
  always @(posedge clk) m_cyc <= rstn ? m_cyc + 32'd1 : 32'd0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] d);
    wvalid = 1'b1;
    wdata  = d;
    if (q.size() < DEPTH) q.push_back({m_cyc, d});
    tick();
    wvalid = 1'b0;
  endtask

  task automatic burst(input int arlen, input bit wr_too, input int wbase,
                       input int stall_beat, input int stall_n);
    logic [511:0] exp;
    bit           was_full;
    pci_arvalid = 1'b1;
    pci_arlen   = 8'(arlen);
    chk("arready", 512'(pci_arready), 512'(1));
    tick();
    pci_arvalid = 1'b0;
    for (int b = 0; b <= arlen; b++) begin
      if (b == stall_beat) begin
        pci_rready = 1'b0;
        wvalid     = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          exp = (q.size() != 0) ? 512'(q[0]) : '0;
          chk("stall_rvalid", 512'(pci_rvalid), 512'(1));
          chk("stall_rdata", pci_rdata, exp);
          chk("stall_size", 512'(size), 512'(q.size()));
          tick();
        end
      end
      pci_rready = 1'b1;
      wvalid     = wr_too;
      wdata      = W'(wbase + b);
      exp = (q.size() != 0) ? 512'(q[0]) : '0;
      chk("rvalid", 512'(pci_rvalid), 512'(1));
      chk("rdata", pci_rdata, exp);
      chk("rlast", 512'(pci_rlast), 512'(b == arlen));
      chk("beat_size", 512'(size), 512'(q.size()));
      was_full = (q.size() >= DEPTH);
      if (q.size() != 0) void'(q.pop_front());
      if (wr_too && !was_full) q.push_back({m_cyc, W'(wbase + b)});
      tick();
    end
    pci_rready = 1'b0;
    wvalid     = 1'b0;
    chk("rvalid_end", 512'(pci_rvalid), 512'(0));
    chk("arready_end", 512'(pci_arready), 512'(1));
  endtask

  task automatic do_reset(input int n);
    rstn        = 1'b0;
    wvalid      = 1'b0;
    pci_arvalid = 1'b0;
    pci_rready  = 1'b0;
    repeat (n) tick();
    rstn = 1'b1;
    q.delete();
  endtask

  logic [7:0] enc_in  [6] = '{8'b0110_1000, 8'b1000_0000, 8'b0000_0001, 8'b0, 8'hFF, 8'b0000_1100};
  logic [2:0] enc_exp [6] = '{3'd3, 3'd7, 3'd0, 3'd0, 3'd0, 3'd2};

  initial begin
    rstn        = 1'b0;
    wvalid      = 1'b0;
    wdata       = '0;
    pci_arvalid = 1'b0;
    pci_arlen   = '0;
    pci_rready  = 1'b0;
    pick_in     = '0;
    repeat (3) tick();
    chk("rst_arready", 512'(pci_arready), 512'(0));
    chk("rst_rvalid", 512'(pci_rvalid), 512'(0));
    chk("rst_rlast", 512'(pci_rlast), 512'(0));
    chk("rst_rdata", pci_rdata, 512'(0));
    chk("rst_size", 512'(size), 512'(0));
    rstn = 1'b1;
    #1;
    chk("post_rst_arready", 512'(pci_arready), 512'(1));
    tick();

    // Three writes then a three-beat burst
    wr(32'd1); wr(32'd2); wr(32'd3);
    chk("size_3", 512'(size), 512'(3));
    burst(2, 1'b0, 0, -1, 0);
    chk("size_after_3", 512'(size), 512'(0));

    // Fill past capacity: only the first 16 are kept
    do_reset(2);
    for (int i = 0; i < 20; i++) wr(W'(i));
    chk("size_full", 512'(size), 512'(16));
    burst(15, 1'b0, 0, -1, 0);
    chk("size_drained", 512'(size), 512'(0));

    // Empty read returns zero beats
    burst(3, 1'b0, 0, -1, 0);
    chk("size_empty", 512'(size), 512'(0));

    // Simultaneous push and pop
    for (int i = 0; i < 5; i++) wr(W'(100 + i));
    chk("size_5", 512'(size), 512'(5));
    burst(7, 1'b1, 200, -1, 0);
    chk("size_still_5", 512'(size), 512'(5));

    // Backpressure for 10 cycles on the second beat
    burst(2, 1'b0, 0, 1, 10);
    chk("size_after_bp", 512'(size), 512'(2));

    // Reset in the middle of a burst
    pci_arvalid = 1'b1;
    pci_arlen   = 8'd3;
    tick();
    pci_arvalid = 1'b0;
    pci_rready  = 1'b1;
    tick();
    rstn       = 1'b0;
    pci_rready = 1'b0;
    tick();
    chk("mid_rst_rvalid", 512'(pci_rvalid), 512'(0));
    chk("mid_rst_size", 512'(size), 512'(0));
    chk("mid_rst_arready", 512'(pci_arready), 512'(0));
    rstn = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_idle", 512'(pci_arready), 512'(1));
    tick();
    chk("no_beat_1", 512'(pci_rvalid), 512'(0));
    tick();
    chk("no_beat_2", 512'(pci_rvalid), 512'(0));

    // Lowest-set-bit encoder
    for (int i = 0; i < 6; i++) begin
      pick_in = enc_in[i];
      #1;
      chk("pick", 512'(pick_out), 512'(enc_exp[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
